crypto_ledger: RTL
==================

Name: crypto_ledger

Overview:
- Transaction engine that owns the user's dollar and coin balances (BTC, ETH, XRP, LTC).
- Sits directly upstream of the balance display; its five balance outputs drive the display's balance inputs one-to-one.
- Accepts one deposit, withdraw, buy or sell request at a time over a valid/ready handshake.
- Converts coin amounts to dollars with a sequential shift-add multiplier, then validates and commits atomically.

Parameters:
W, 16, width of every balance, amount and price.
INIT_DOLLARS, 1000, dollar balance loaded at reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high; one clock domain only
req_valid  input  1  request present
req_ready  output  1  engine idle and able to accept
req_op  input  2  00 deposit dollars, 01 withdraw dollars, 10 buy coin, 11 sell coin
req_coin  input  2  00 BTC, 01 ETH, 10 XRP, 11 LTC (ignored for 00/01)
req_amount  input  W  dollars for 00/01; coin units for 10/11
price_btc, price_eth, price_xrp, price_ltc  input  W each  dollars per coin unit
balance_dollars_out, balance_btc, balance_eth, balance_xrp, balance_ltc  output  W each  registered balances
done  output  1  one-cycle pulse, transaction finished
status  output  2  result of last transaction: 00 OK, 01 insufficient funds, 10 overflow

Behaviour:
- Reset (async, immediate):
  - balance_dollars_out=INIT_DOLLARS; all coin balances 0.
  - state IDLE, done=0, status=00, req_ready=1.
  - Asserting rst mid-transaction aborts it; no partial commit and no done pulse.
- States: IDLE, MUL, EXEC.
- req_ready = (state==IDLE).
- Accept: on an edge with req_valid & req_ready, latch op, coin, amount and the selected coin's price. Later price changes do not affect the transaction in flight.
- IDLE transitions:
  - Op 00/01: go to EXEC; operand = amount zero-extended to 2W.
  - Op 10/11: go to MUL.
- MUL: exactly W cycles of shift-add, one multiplier bit per cycle, producing a 2W-bit product = amount*price. Then go to EXEC.
- EXEC: one cycle. Evaluate the rules below; on the closing edge update balances (if OK), load status, set done=1, go to IDLE.
- done is high for exactly the cycle after EXEC. In that cycle new balances and status are visible and req_ready=1, so a back-to-back request may be accepted on that edge.
- Latency from accepting edge to done cycle: 2 edges for ops 00/01; W+2 edges for ops 10/11.
- Rules. All comparisons are full-width with no truncation; "overflow" means result > 2^W-1.
  - Deposit: dollars+amount overflows -> 10.
  - Withdraw: amount > dollars -> 01.
  - Buy: product > dollars -> 01; else coin+amount overflows -> 10; else dollars -= product, coin += amount.
  - Sell: amount > coin -> 01; else dollars+product overflows -> 10; else coin -= amount, dollars += product.
- Any non-OK status leaves every balance unchanged.
- Insufficient funds (01) takes priority over overflow (10).
- Zero amount or zero price: status 00, balances unchanged, full latency still applies.
- Exact boundaries are OK:
  - Withdraw amount == dollars -> dollars becomes 0.
  - Results exactly 2^W-1 are OK.
- req_valid while busy is ignored; not queued.
- status holds its value until the next done.
- status 11 is never produced.

Test Plan:
- Reset, W=16 -> dollars 1000, all coins 0, req_ready 1, done 0, status 00.
- Buy BTC amount 3, price_btc 200 -> done pulse 18 edges after accept; dollars 400, BTC 3, status 00. Changing price_btc during MUL has no effect.
- Then buy BTC amount 6, price 200 (cost 1200 > 400) -> status 01, balances unchanged. Then sell ETH amount 1 with ETH 0 -> status 01.
- Sell BTC 3 at price 21000 -> dollars 63400, BTC 0, status 00. Then deposit 3000 -> status 10, dollars stays 63400. Then deposit 2135 -> 65535, status 00.
- Withdraw 65536-? check: from dollars 400, withdraw 401 -> 01; withdraw 400 -> dollars 0, status 00. Deposit 50 -> done exactly 2 edges after accept. A request held valid during done is accepted on the done edge.
- Assert rst asynchronously in MUL cycle 5 of a buy -> outputs return immediately to reset values; no done pulse; the next request completes normally.

Source files
------------

// File: rtl/crypto_ledger_if.sv
// Request channel of the ledger engine: one valid/ready handshake carrying
// the operation, the coin selector and the amount.
interface crypto_ledger_if #(
  parameter int W = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [1:0]   req_coin;
  logic [W-1:0] req_amount;

  modport master (
    output req_valid, req_op, req_coin, req_amount,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_coin, req_amount,
    output req_ready
  );
endinterface

// File: rtl/crypto_ledger.sv
// Dollar/coin ledger engine: accepts one request at a time, prices coin amounts
// with a W-cycle shift-add multiplier, then validates and commits atomically.
module crypto_ledger #(
  parameter int W            = 16,
  parameter int INIT_DOLLARS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  crypto_ledger_if.slave   req,
  input  logic [W-1:0]     price_btc,
  input  logic [W-1:0]     price_eth,
  input  logic [W-1:0]     price_xrp,
  input  logic [W-1:0]     price_ltc,
  output logic [W-1:0]     balance_dollars_out,
  output logic [W-1:0]     balance_btc,
  output logic [W-1:0]     balance_eth,
  output logic [W-1:0]     balance_xrp,
  output logic [W-1:0]     balance_ltc,
  output logic             done,
  output logic [1:0]       status
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, EXEC = 2'd2;
  localparam logic [1:0] OP_DEP = 2'b00, OP_WD = 2'b01, OP_BUY = 2'b10, OP_SELL = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_INS = 2'b01, ST_OVF = 2'b10;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]     state_q;
  logic [1:0]     op_q, coin_q;
  logic [W-1:0]   amt_q, mplier_q;
  logic [2*W-1:0] mcand_q, prod_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   dollars_q;
  logic [W-1:0]   coins_q [4];
  logic           done_q;
  logic [1:0]     status_q;

  logic [W-1:0]   price_sel;
  logic [W-1:0]   coin_cur;
  logic [2*W:0]   dsum;
  logic [W:0]     csum;
  logic [1:0]     status_d;
  logic [W-1:0]   dollars_d, coin_d;

  assign req.req_ready = (state_q == IDLE);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    price_sel = price_btc;
    case (req.req_coin)
      2'd1:    price_sel = price_eth;
      2'd2:    price_sel = price_xrp;
      2'd3:    price_sel = price_ltc;
      default: price_sel = price_btc;
    endcase
  end

  // Deposit/withdraw carry the dollar amount in prod_q, so one adder serves deposit and sell.
  assign coin_cur = coins_q[coin_q];
  assign dsum     = {1'b0, prod_q} + {{(W+1){1'b0}}, dollars_q};
  assign csum     = {1'b0, coin_cur} + {1'b0, amt_q};

  always_comb begin
    status_d  = ST_OK;
    dollars_d = dollars_q;
    coin_d    = coin_cur;
    case (op_q)
      OP_DEP: begin
        if (dsum[2*W:W] != '0) status_d = ST_OVF;
        else                   dollars_d = dsum[W-1:0];
      end
      OP_WD: begin
        if (prod_q > {{W{1'b0}}, dollars_q}) status_d = ST_INS;
        else                                 dollars_d = dollars_q - amt_q;
      end
      OP_BUY: begin
        if (prod_q > {{W{1'b0}}, dollars_q}) status_d = ST_INS;
        else if (csum[W])                    status_d = ST_OVF;
        else begin
          dollars_d = dollars_q - prod_q[W-1:0];
          coin_d    = csum[W-1:0];
        end
      end
      default: begin
        if (amt_q > coin_cur)            status_d = ST_INS;
        else if (dsum[2*W:W] != '0)      status_d = ST_OVF;
        else begin
          dollars_d = dsum[W-1:0];
          coin_d    = coin_cur - amt_q;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      coin_q    <= '0;
      amt_q     <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      dollars_q <= W'(INIT_DOLLARS);
      // NOTE: the four coin registers are architectural state, not RAM, so each is reset explicitly.
      for (int i = 0; i < 4; i++) coins_q[i] <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            op_q     <= req.req_op;
            coin_q   <= req.req_coin;
            amt_q    <= req.req_amount;
            mplier_q <= req.req_amount;
            mcand_q  <= {{W{1'b0}}, price_sel};
            cnt_q    <= '0;
            if (req.req_op[1]) begin
              prod_q  <= '0;
              state_q <= MUL;
            end else begin
              prod_q  <= {{W{1'b0}}, req.req_amount};
              state_q <= EXEC;
            end
          end
        end
        MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= EXEC;
        end
        EXEC: begin
          status_q <= status_d;
          done_q   <= 1'b1;
          if (status_d == ST_OK) begin
            dollars_q       <= dollars_d;
            coins_q[coin_q] <= coin_d;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign balance_dollars_out = dollars_q;
  assign balance_btc         = coins_q[0];
  assign balance_eth         = coins_q[1];
  assign balance_xrp         = coins_q[2];
  assign balance_ltc         = coins_q[3];
  assign done                = done_q;
  assign status              = status_q;
endmodule
